// File: rtl/p2s_tx_arbiter_if.sv
// Requester/shifter bundle for p2s_tx_arbiter.
// master = arbiter side, slave = requesters plus shifter.
interface p2s_tx_arbiter_if #(
  parameter int WIDTH = 8,
  parameter int NREQ  = 4
);
  localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]       req_valid;
  logic [NREQ*WIDTH-1:0] req_data;
  logic [NREQ-1:0]       req_ready;
  logic                  p2s_load;
  logic [WIDTH-1:0]      p2s_data;
  logic                  p2s_valid;
  logic [GW-1:0]         grant_id;
  logic                  busy;
  logic                  done;
  logic                  error;

  modport master (
    input  req_valid,
    input  req_data,
    input  p2s_valid,
    output req_ready,
    output p2s_load,
    output p2s_data,
    output grant_id,
    output busy,
    output done,
    output error
  );

  modport slave (
    output req_valid,
    output req_data,
    output p2s_valid,
    input  req_ready,
    input  p2s_load,
    input  p2s_data,
    input  grant_id,
    input  busy,
    input  done,
    input  error
  );
endinterface

// File: rtl/p2s_tx_arbiter.sv
// Round-robin arbiter sharing one parallel2serial shifter.
// Tracks the shifter's valid stream and flags done / framing error.
module p2s_tx_arbiter #(
  parameter int WIDTH         = 8,
  parameter int NREQ          = 4,
  parameter int START_TIMEOUT = 4
) (
  input  logic clk,
  input  logic rst,
  p2s_tx_arbiter_if.master bus
);
  localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(WIDTH + 1);
  localparam int TW = $clog2(START_TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    WAIT_START,
    SHIFT
  } state_e;

  state_e           state_q, state_d;
  logic [GW-1:0]    rr_q, rr_d;
  logic [GW-1:0]    gid_q, gid_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [TW-1:0]    tmo_q, tmo_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  logic             hit;
  logic [GW-1:0]    pick;
  logic [GW-1:0]    idx;
  logic [WIDTH-1:0] pick_word;

  // First active requester at or after rr_q, wrapping.
  always_comb begin
    hit  = 1'b0;
    pick = '0;
    idx  = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = GW'((int'(rr_q) + k) % NREQ);
      if (!hit && bus.req_valid[idx]) begin
        hit  = 1'b1;
        pick = idx;
      end
    end
  end

  always_comb begin
    pick_word = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (GW'(i) == pick) begin
        pick_word = bus.req_data[i*WIDTH +: WIDTH];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rr_q    <= '0;
      gid_q   <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
      tmo_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      gid_q   <= gid_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    gid_d   = gid_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    tmo_d   = tmo_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (hit) begin
          state_d = LOAD;
          gid_d   = pick;
          data_d  = pick_word;
        end
      end
      LOAD: begin
        state_d = WAIT_START;
        rr_d    = (gid_q == GW'(NREQ - 1)) ? '0 : gid_q + 1'b1;
        tmo_d   = '0;
        cnt_d   = '0;
      end
      WAIT_START: begin
        if (bus.p2s_valid) begin
          cnt_d = CW'(1);
          if (WIDTH == 1) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            state_d = SHIFT;
          end
        end else if (tmo_q == TW'(START_TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      SHIFT: begin
        if (bus.p2s_valid) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CW'(WIDTH - 1)) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end else begin
          err_d   = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs decode flops only; no input reaches them combinationally.
  always_comb begin
    bus.p2s_load  = (state_q == LOAD);
    bus.req_ready = (state_q == LOAD) ? (NREQ'(1) << gid_q) : '0;
    bus.p2s_data  = data_q;
    bus.grant_id  = gid_q;
    bus.busy      = (state_q != IDLE);
    bus.done      = done_q;
    bus.error     = err_q;
  end
endmodule

// File: tb/tb_p2s_tx_arbiter.sv
// Directed bench for p2s_tx_arbiter with a grant/word scoreboard.
// The bench plays both the requesters and the shifter.
module tb_p2s_tx_arbiter;
  localparam int W  = 8;
  localparam int N  = 4;
  localparam int TO = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  p2s_tx_arbiter_if #(.WIDTH(W), .NREQ(N)) bus ();

  p2s_tx_arbiter #(
    .WIDTH(W),
    .NREQ(N),
    .START_TIMEOUT(TO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;
  logic [15:0] sb[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int g, input logic [7:0] d);
    sb.push_back({8'(g), d});
  endtask

  task automatic set_word(input int i, input logic [7:0] d);
    bus.req_data[i*W +: W] = d;
  endtask

  task automatic wait_load(output int lat);
    logic [15:0] e;
    logic [3:0]  r;
    lat = 0;
    do begin
      tick();
      lat++;
    end while (!bus.p2s_load && lat < 40);
    chk("load_seen", bus.p2s_load, 1);
    e = (sb.size() > 0) ? sb.pop_front() : 16'hFFFF;
    r = 4'b0001 << e[9:8];
    chk("grant_id", bus.grant_id, e[15:8]);
    chk("p2s_data", bus.p2s_data, e[7:0]);
    chk("req_ready", bus.req_ready, r);
    chk("no_done_at_load", bus.done, 0);
    chk("no_err_at_load", bus.error, 0);
  endtask

  task automatic run_shift(input int nbits);
    for (int i = 0; i < nbits; i++) begin
      tick();
      bus.p2s_valid = 1'b1;
      chk("busy_run", bus.busy, 1);
      chk("no_done_run", bus.done, 0);
      chk("no_err_run", bus.error, 0);
    end
    tick();
    bus.p2s_valid = 1'b0;
    if (nbits == W) begin
      chk("done", bus.done, 1);
      chk("done_no_err", bus.error, 0);
      chk("busy_after_done", bus.busy, 0);
      chk("no_load_done", bus.p2s_load, 0);
    end else if (nbits == 0) begin
      chk("tmo_err_early", bus.error, 0);
      for (int i = 0; i < TO - 1; i++) begin
        tick();
        chk("tmo_err_early", bus.error, 0);
        chk("tmo_busy", bus.busy, 1);
      end
      tick();
      chk("tmo_err", bus.error, 1);
      chk("tmo_no_done", bus.done, 0);
      chk("tmo_idle", bus.busy, 0);
    end else begin
      chk("drop_err_early", bus.error, 0);
      chk("drop_busy", bus.busy, 1);
      tick();
      chk("drop_err", bus.error, 1);
      chk("drop_no_done", bus.done, 0);
      chk("drop_idle", bus.busy, 0);
    end
  endtask

  initial begin
    int lat;
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.p2s_valid = 1'b0;
    rst = 1'b1;
    repeat (3) tick();
    chk("rst_load", bus.p2s_load, 0);
    chk("rst_data", bus.p2s_data, 0);
    chk("rst_ready", bus.req_ready, 0);
    chk("rst_gid", bus.grant_id, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_err", bus.error, 0);

    // Single request
    rst = 1'b0;
    set_word(0, 8'hAA);
    bus.req_valid = 4'b0001;
    push(0, 8'hAA);
    wait_load(lat);
    chk("load_latency", lat, 1);
    bus.req_valid = '0;
    run_shift(W);
    tick();
    chk("done_pulse_1cyc", bus.done, 0);
    chk("data_held", bus.p2s_data, 8'hAA);
    chk("idle_busy", bus.busy, 0);

    // All four continuous, from a fresh rr pointer
    rst = 1'b1;
    tick();
    rst = 1'b0;
    set_word(0, 8'h11);
    set_word(1, 8'h22);
    set_word(2, 8'h33);
    set_word(3, 8'h44);
    bus.req_valid = 4'b1111;
    push(0, 8'h11);
    push(1, 8'h22);
    push(2, 8'h33);
    push(3, 8'h44);
    push(0, 8'h11);
    for (int k = 0; k < 5; k++) begin
      wait_load(lat);
      chk("rr_back_to_back", lat, 1);
      if (k == 4) bus.req_valid = '0;
      run_shift(W);
    end

    // Serve 2, then 0101 wraps to 0, then 2 again
    set_word(2, 8'h55);
    bus.req_valid = 4'b0100;
    push(2, 8'h55);
    wait_load(lat);
    bus.req_valid = '0;
    run_shift(W);
    set_word(0, 8'h11);
    set_word(2, 8'h33);
    bus.req_valid = 4'b0101;
    push(0, 8'h11);
    push(2, 8'h33);
    wait_load(lat);
    bus.req_valid = 4'b0100;
    run_shift(W);
    wait_load(lat);
    bus.req_valid = '0;
    run_shift(W);

    // Start timeout, then a fresh request is accepted
    set_word(1, 8'h5A);
    bus.req_valid = 4'b0010;
    push(1, 8'h5A);
    wait_load(lat);
    bus.req_valid = '0;
    run_shift(0);
    set_word(3, 8'hC3);
    bus.req_valid = 4'b1000;
    push(3, 8'hC3);
    wait_load(lat);
    chk("accept_after_tmo", lat, 1);
    bus.req_valid = '0;
    run_shift(W);

    // Valid drops after 5 bits
    set_word(0, 8'h0F);
    bus.req_valid = 4'b0001;
    push(0, 8'h0F);
    wait_load(lat);
    bus.req_valid = '0;
    run_shift(5);

    // Reset in SHIFT at bit 3
    set_word(2, 8'h77);
    bus.req_valid = 4'b0100;
    push(2, 8'h77);
    wait_load(lat);
    bus.req_valid = '0;
    for (int i = 0; i < 3; i++) begin
      tick();
      bus.p2s_valid = 1'b1;
    end
    rst = 1'b1;
    tick();
    bus.p2s_valid = 1'b0;
    chk("mid_rst_load", bus.p2s_load, 0);
    chk("mid_rst_data", bus.p2s_data, 0);
    chk("mid_rst_ready", bus.req_ready, 0);
    chk("mid_rst_gid", bus.grant_id, 0);
    chk("mid_rst_busy", bus.busy, 0);
    chk("mid_rst_done", bus.done, 0);
    chk("mid_rst_err", bus.error, 0);
    rst = 1'b0;
    bus.req_valid = 4'b1010;
    push(1, 8'h5A);
    wait_load(lat);
    chk("post_rst_latency", lat, 1);
    bus.req_valid = '0;
    run_shift(W);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
